extbus_master_6502: RTL and testbench
=====================================

Name: extbus_master_6502

Overview:
- 6502-style bus initiator: converts a valid/ready command stream (register index, write data, rw) into 6502 bus cycles on phi2/cs_n/rw_n/a/d.
- Drives the same external bus our 6502 slave interface responds to, from the opposite end.
- Used as a board-level host controller and as the stimulus master in system benches.
- Also synchronizes the open-drain IRQ line back into the clk domain.

Parameters:
- PHI2_LOW_CYCLES, 6, clk cycles per phi2-low phase; must satisfy >= HOLD_CYCLES+2.
- PHI2_HIGH_CYCLES, 6, clk cycles per phi2-high phase; must be >= 1. The default lets a slave on the same clk return port read data within the cycle.
- HOLD_CYCLES, 2, clk cycles that a, rw_n, cs_n and write data stay valid after phi2 falls.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this clk.
- cmd_addr  in  3  register index.
- cmd_write  in  1  1=write, 0=read.
- cmd_wrdata  in  8  write data.
- rsp_valid  out  1  one-clk pulse, bus cycle complete.
- rsp_rddata  out  8  read data captured; holds its value until the next read.
- irq  out  1  synchronized, active-high IRQ.
- extbus_phi2  out  1  bus clock, free-running.
- extbus_cs_n  out  1  chip select.
- extbus_rw_n  out  1  read(1)/write(0).
- extbus_a  out  3  address.
- extbus_d  inout  8  data; driven only during write cycles, Z otherwise.
- extbus_irq_n  in  1  open-drain IRQ; pulled up at top level, Z reads as 1.

Behaviour:
- Reset values:
  - phi2=0, cs_n=1, rw_n=1, a=0, d=Z, cmd_ready=0, rsp_valid=0, rsp_rddata=0, irq=0.
  - Phase counter restarts at low-phase index 0.
- Phase generator:
  - Low phase runs indices 0..LOW-1, then high phase runs 0..HIGH-1, then repeats.
  - phi2 is registered: 1 exactly during the high phase.
  - The generator runs whether or not commands are present.
- Acceptance:
  - cmd_ready=1 only at low index HOLD_CYCLES, and only when cmd_valid=1.
  - The command is latched on that edge.
  - cmd_valid must stay stable until accepted; changing it while unaccepted is undefined.
- Address phase (from low index HOLD+1 to the end of low): cs_n=0, a=cmd_addr, rw_n=!cmd_write.
  - One clk with cs_n=1 always separates consecutive transactions (at low index HOLD).
- Data phase (entire high phase):
  - Write: d driven with wrdata.
  - Read: d released, and extbus_d is sampled into rsp_rddata at high index HIGH-1.
- Completion:
  - rsp_valid pulses on the clk where phi2 returns low (low index 0), for both reads and writes.
  - Latency from acceptance to rsp_valid = (LOW-1-HOLD) + HIGH + 1 clks. Defaults give 10.
- Hold (low indices 0..HOLD-1): a, rw_n, cs_n=0 and write data are held. After that: cs_n=1, rw_n=1, d=Z, a keeps its last value.
- Idle bus cycle (no command at acceptance point): phi2 still toggles, cs_n=1, rw_n=1, d=Z, no rsp_valid.
- Back-to-back: a command can be accepted every bus period, which gives full throughput.
- IRQ: two-flop synchronizer on extbus_irq_n; irq = !sync2. Latency is 2 clks, with no filtering.
- Reset mid-transaction:
  - Aborts immediately, with no rsp_valid.
  - Bus returns to idle values on the next clk.
  - The in-flight command is dropped; the source must reissue it.
- Parameter violation (LOW < HOLD+2 or HIGH < 1): elaboration-time error via a generate-time check.

Decomposition:
- Shared package extbus_6502_pkg, also used by the slave-side benches:
  - Register index constants: 0 ADDR_H_INCR, 1 ADDR_M, 2 ADDR_L, 3 DATA0, 4 DATA1, 5 CTRL, 6 IEN, 7 ISR.
  - CTRL bit positions: ADDRSEL=0, WARMBOOT=7.
- Sub-module extbus_phi2_gen (parameters LOW/HIGH): outputs phi2, phase, index, and rise/fall strobes.
- The top level holds the transaction FSM (IDLE_BUS, ADDR, DATA, HOLD) and the IRQ synchronizer.

Test Plan:
- Write 0x12 to addr 2 (defaults):
  - cmd_ready one clk at low index 2.
  - cs_n=0, a=2, rw_n=0 from index 3.
  - d=0x12 for the 6 high clks, held 2 clks after the fall.
  - rsp_valid 10 clks after acceptance.
- Read addr 7 with a slave model returning 0xA5: rsp_rddata=0xA5 and rsp_valid at the phi2 fall; d never driven by the master.
- Three back-to-back writes (addr 0,1,2):
  - Exactly one period (12 clks) apart.
  - cs_n high exactly 1 clk between them.
  - Three rsp_valid pulses.
- No command for 5 periods: phi2 toggles with period 12, cs_n stays 1, no rsp_valid; rst asserted in the high phase drops everything to reset values on the next clk.
- extbus_irq_n driven 0 then Z with pullup: irq rises 2 clks later, then falls 2 clks after release.
- Loopback against the 6502 slave with memory model:
  - Write ADDR_H=0x10, ADDR_M=0x00, ADDR_L=0x40, then DATA0=0x5A.
  - Re-program the address, then read DATA0, which returns 0x5A.
  - Read ADDR_L, which returns 0x41 (increment 1).

Source files
------------

// File: rtl/extbus_6502_pkg.sv
// Shared definitions for the 6502-style external bus: register map, CTRL bits,
// master FSM states and a width helper for the phase counter.
package extbus_6502_pkg;

  localparam logic [2:0] ADDR_H_INCR = 3'd0;
  localparam logic [2:0] ADDR_M      = 3'd1;
  localparam logic [2:0] ADDR_L      = 3'd2;
  localparam logic [2:0] DATA0       = 3'd3;
  localparam logic [2:0] DATA1       = 3'd4;
  localparam logic [2:0] CTRL        = 3'd5;
  localparam logic [2:0] IEN         = 3'd6;
  localparam logic [2:0] ISR         = 3'd7;

  localparam int unsigned CTRL_ADDRSEL  = 0;
  localparam int unsigned CTRL_WARMBOOT = 7;

  typedef enum logic [1:0] {
    StIdleBus,
    StAddr,
    StData,
    StHold
  } bus_state_e;

  function automatic int unsigned idx_width(input int unsigned low, input int unsigned high);
    int unsigned m;
    m = (low > high) ? low : high;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/extbus_phi2_gen.sv
// Free-running phi2 generator: LOW clks low, HIGH clks high, with phase index
// and strobes marking the last clk before phi2 rises or falls.
module extbus_phi2_gen
  import extbus_6502_pkg::*;
#(
  parameter int unsigned LOW  = 6,
  parameter int unsigned HIGH = 6,
  localparam int unsigned IdxW = idx_width(LOW, HIGH)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            phi2,
  output logic            phase,
  output logic [IdxW-1:0] index,
  output logic            rise,
  output logic            fall
);

  logic            phase_q, phase_d;
  logic [IdxW-1:0] idx_q, idx_d;

  // Strobes are high on the last clk of a phase; phi2 toggles at the closing edge.
  assign rise = !phase_q && (idx_q == IdxW'(LOW - 1));
  assign fall = phase_q && (idx_q == IdxW'(HIGH - 1));

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q + IdxW'(1);
    if (rise) begin
      phase_d = 1'b1;
      idx_d   = '0;
    end else if (fall) begin
      phase_d = 1'b0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign phi2  = phase_q;
  assign phase = phase_q;
  assign index = idx_q;

endmodule

// File: rtl/extbus_master_6502.sv
// 6502-style bus initiator: turns valid/ready commands into phi2 bus cycles and
// synchronizes the open-drain IRQ line into the clk domain.
module extbus_master_6502
  import extbus_6502_pkg::*;
#(
  parameter int unsigned PHI2_LOW_CYCLES  = 6,
  parameter int unsigned PHI2_HIGH_CYCLES = 6,
  parameter int unsigned HOLD_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_addr,
  input  logic       cmd_write,
  input  logic [7:0] cmd_wrdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rddata,
  output logic       irq,
  output logic       extbus_phi2,
  output logic       extbus_cs_n,
  output logic       extbus_rw_n,
  output logic [2:0] extbus_a,
  inout  wire  [7:0] extbus_d,
  input  logic       extbus_irq_n
);

  localparam int unsigned IdxW    = idx_width(PHI2_LOW_CYCLES, PHI2_HIGH_CYCLES);
  localparam bit          HasHold = (HOLD_CYCLES > 0);

  if (PHI2_LOW_CYCLES < HOLD_CYCLES + 2 || PHI2_HIGH_CYCLES < 1) begin : g_param_check
    $error("extbus_master_6502: need LOW >= HOLD+2 and HIGH >= 1");
  end

  logic            phi2, phase, rise, fall;
  logic [IdxW-1:0] index;

  extbus_phi2_gen #(
    .LOW  (PHI2_LOW_CYCLES),
    .HIGH (PHI2_HIGH_CYCLES)
  ) u_phi2_gen (
    .clk   (clk),
    .rst   (rst),
    .phi2  (phi2),
    .phase (phase),
    .index (index),
    .rise  (rise),
    .fall  (fall)
  );

  bus_state_e state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic       write_q, write_d;
  logic [7:0] wrdata_q, wrdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rddata_q, rddata_d;
  logic       sync1_q, sync2_q;
  logic       drive_d;

  // The single acceptance slot doubles as the cs_n-high gap between transactions.
  assign cmd_ready = cmd_valid && !rst && (state_q == StIdleBus) && !phase &&
                     (index == IdxW'(HOLD_CYCLES));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wrdata_d    = wrdata_q;
    rsp_valid_d = 1'b0;
    rddata_d    = rddata_q;
    unique case (state_q)
      StIdleBus: begin
        if (cmd_ready) begin
          state_d  = StAddr;
          addr_d   = cmd_addr;
          write_d  = cmd_write;
          wrdata_d = cmd_wrdata;
        end
      end
      StAddr: begin
        if (rise) state_d = StData;
      end
      StData: begin
        if (fall) begin
          state_d     = HasHold ? StHold : StIdleBus;
          rsp_valid_d = 1'b1;
          if (!write_q) rddata_d = extbus_d;
        end
      end
      StHold: begin
        if (!phase && (index == IdxW'(HOLD_CYCLES - 1))) state_d = StIdleBus;
      end
      default: state_d = StIdleBus;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdleBus;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wrdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rddata_q    <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wrdata_q    <= wrdata_d;
      rsp_valid_q <= rsp_valid_d;
      rddata_q    <= rddata_d;
      sync1_q     <= extbus_irq_n;
      sync2_q     <= sync1_q;
    end
  end

  assign drive_d     = write_q && ((state_q == StData) || (state_q == StHold));
  assign extbus_d    = drive_d ? wrdata_q : 'z;
  assign extbus_phi2 = phi2;
  assign extbus_cs_n = (state_q == StIdleBus);
  assign extbus_rw_n = (state_q == StIdleBus) || !write_q;
  assign extbus_a    = addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rddata  = rddata_q;
  assign irq         = !sync2_q;

endmodule

// File: tb/tb_extbus_master_6502.sv
// Bench for extbus_master_6502: bus-cycle timing model driven by a cycle count
// since reset, plus a behavioural 6502 slave with auto-incrementing memory.
module tb_extbus_master_6502;
  import extbus_6502_pkg::*;

  localparam int LOW    = 6;
  localparam int HIGH   = 6;
  localparam int HOLD   = 2;
  localparam int P      = LOW + HIGH;
  localparam int HI_D   = LOW - HOLD;       // clks from acceptance to first high clk
  localparam int RSP_D  = HI_D + HIGH;      // acceptance -> rsp_valid
  localparam int LAST_D = RSP_D + HOLD - 1; // last clk with cs_n low

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wrdata;
  logic       rsp_valid, irq;
  logic [7:0] rsp_rddata;
  logic       extbus_phi2, extbus_cs_n, extbus_rw_n, extbus_irq_n;
  logic [2:0] extbus_a;
  wire  [7:0] extbus_d;
  logic       irq_low;

  // Released open-drain line reads as the pulled-up 1.
  assign extbus_irq_n = !irq_low;

  extbus_master_6502 #(
    .PHI2_LOW_CYCLES  (LOW),
    .PHI2_HIGH_CYCLES (HIGH),
    .HOLD_CYCLES      (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_write    (cmd_write),
    .cmd_wrdata   (cmd_wrdata),
    .rsp_valid    (rsp_valid),
    .rsp_rddata   (rsp_rddata),
    .irq          (irq),
    .extbus_phi2  (extbus_phi2),
    .extbus_cs_n  (extbus_cs_n),
    .extbus_rw_n  (extbus_rw_n),
    .extbus_a     (extbus_a),
    .extbus_d     (extbus_d),
    .extbus_irq_n (extbus_irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [7:0] regs [8];
  logic [7:0] mem  [1024];
  logic [7:0] slv_val;
  bit         mon_on = 0;

  function automatic logic [9:0] slave_ptr();
    logic [19:0] p;
    p = {regs[0][3:0], regs[1], regs[2]};
    return p[9:0];
  endfunction

  function automatic logic [7:0] slave_peek(input logic [2:0] ad);
    if (ad == DATA0 || ad == DATA1) return mem[slave_ptr()];
    return regs[ad];
  endfunction

  task automatic slave_incr();
    logic [19:0] p;
    p = {regs[0][3:0], regs[1], regs[2]} + 20'(regs[0][7:4]);
    regs[0][3:0] = p[19:16];
    regs[1]      = p[15:8];
    regs[2]      = p[7:0];
  endtask

  always @(posedge extbus_phi2) slv_val <= slave_peek(extbus_a);
  assign extbus_d = (!extbus_cs_n && extbus_rw_n && extbus_phi2) ? slv_val : 8'bz;

  always @(negedge extbus_phi2) begin
    if (mon_on && !rst && !extbus_cs_n) begin
      if (extbus_rw_n) begin
        if (extbus_a == DATA0) slave_incr();
      end else if (extbus_a == DATA0) begin
        mem[slave_ptr()] = extbus_d;
        slave_incr();
      end else if (extbus_a == DATA1) begin
        mem[slave_ptr()] = extbus_d;
      end else begin
        regs[extbus_a] = extbus_d;
      end
    end
  end

  // ---------------- reference model ----------------
  int         k  = 0;      // clks since reset; k % P is the position in the bus period
  int         ka = -1000;  // k of the last accepted command
  logic       m_wr = 1'b0;
  logic [7:0] m_data = '0, pend_rd = '0, exp_rd = '0;
  logic [2:0] exp_a = '0;
  logic [1:0] irq_h = '0;
  int         rsp_cnt = 0, rise_cnt = 0;
  logic       phi2_prev = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k      <= 0;
      ka     <= -1000;
      exp_a  <= '0;
      exp_rd <= '0;
      irq_h  <= '0;
    end else begin
      k     <= k + 1;
      irq_h <= {irq_h[0], irq_low};
      if (cmd_valid && (k % P) == HOLD) begin
        ka      <= k;
        m_wr    <= cmd_write;
        m_data  <= cmd_wrdata;
        exp_a   <= cmd_addr;
        pend_rd <= slave_peek(cmd_addr);
      end
      if (!m_wr && (k - ka) == RSP_D - 1) exp_rd <= pend_rd;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      int   d;
      logic act;
      d   = k - ka;
      act = (d >= 1) && (d <= LAST_D);
      check_eq("phi2", 32'(extbus_phi2), 32'((k % P) >= LOW));
      check_eq("cmd_ready", 32'(cmd_ready), 32'(cmd_valid && !rst && (k % P) == HOLD));
      check_eq("cs_n", 32'(extbus_cs_n), 32'(!act));
      check_eq("rw_n", 32'(extbus_rw_n), act ? 32'(!m_wr) : 32'd1);
      check_eq("addr", 32'(extbus_a), 32'(exp_a));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(d == RSP_D));
      check_eq("rsp_rddata", 32'(rsp_rddata), 32'(exp_rd));
      check_eq("irq", 32'(irq), 32'(irq_h[1]));
      if (act && m_wr && d >= HI_D) check_eq("wr_data", 32'(extbus_d), 32'(m_data));
      if (act && !m_wr && d >= HI_D && d < HI_D + HIGH)
        check_eq("rd_bus", 32'(extbus_d), 32'(pend_rd));
      if (rsp_valid) rsp_cnt++;
      if (extbus_phi2 && !phi2_prev) rise_cnt++;
      phi2_prev = extbus_phi2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic wr, input logic [2:0] ad, input logic [7:0] dt,
                      output int acc_k);
    bit got;
    got        = 0;
    acc_k      = -1;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = ad;
    cmd_wrdata = dt;
    for (int i = 0; i < 3 * P && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got   = 1;
        acc_k = k;
      end
    end
    check_eq("accept", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc_k, output int lat);
    bit got;
    got = 0;
    lat = -1;
    for (int i = 0; i < 3 * P && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        lat = k - acc_k;
      end
    end
    check_eq("rsp_timeout", 32'(got), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, a2, lat, r0, r1;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    regs[ISR]  = 8'hA5;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wrdata = '0;
    irq_low    = 1'b0;

    @(posedge clk);
    #1;
    mon_on = 1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_phi2", 32'(extbus_phi2), 32'd0);
    check_eq("rst_cs_n", 32'(extbus_cs_n), 32'd1);
    check_eq("rst_rw_n", 32'(extbus_rw_n), 32'd1);
    check_eq("rst_a", 32'(extbus_a), 32'd0);
    check_eq("rst_rsp", 32'(rsp_rddata), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write
    send(1'b1, 3'd2, 8'h12, a0);
    check_eq("wr_ready_idx", 32'(a0 % P), 32'(HOLD));
    wait_rsp(a0, lat);
    check_eq("wr_latency", 32'(lat), 32'd10);

    // Read of ISR
    @(posedge clk);
    #1;
    send(1'b0, ISR, 8'h00, a0);
    wait_rsp(a0, lat);
    check_eq("rd_latency", 32'(lat), 32'd10);
    check_eq("rd_isr", 32'(rsp_rddata), 32'hA5);

    // Three back-to-back writes
    @(posedge clk);
    #1;
    r0 = rsp_cnt;
    send(1'b1, 3'd0, 8'h21, a0);
    send(1'b1, 3'd1, 8'h22, a1);
    send(1'b1, 3'd2, 8'h23, a2);
    check_eq("b2b_gap1", 32'(a1 - a0), 32'(P));
    check_eq("b2b_gap2", 32'(a2 - a1), 32'(P));
    repeat (2 * P) @(posedge clk);
    #1;
    check_eq("b2b_rsp_cnt", 32'(rsp_cnt - r0), 32'd3);

    // Five idle periods
    r0 = rsp_cnt;
    r1 = rise_cnt;
    repeat (5 * P) @(posedge clk);
    #1;
    check_eq("idle_rises", 32'(rise_cnt - r1), 32'd5);
    check_eq("idle_rsp", 32'(rsp_cnt - r0), 32'd0);

    // Reset in the high phase of a write
    r0 = rsp_cnt;
    send(1'b1, CTRL, 8'h77, a0);
    for (int i = 0; i < 2 * P && (k % P) != LOW + 1; i++) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_cs_n", 32'(extbus_cs_n), 32'd1);
    check_eq("abort_phi2", 32'(extbus_phi2), 32'd0);
    check_eq("abort_a", 32'(extbus_a), 32'd0);
    rst = 1'b0;
    repeat (2 * P) @(posedge clk);
    #1;
    check_eq("abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    // IRQ synchronizer
    irq_low = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("irq_rise_1clk", 32'(irq), 32'd0);
    @(negedge clk);
    check_eq("irq_rise_2clk", 32'(irq), 32'd1);
    @(posedge clk);
    #1;
    irq_low = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("irq_fall_1clk", 32'(irq), 32'd1);
    @(negedge clk);
    check_eq("irq_fall_2clk", 32'(irq), 32'd0);

    // Loopback through the slave memory
    @(posedge clk);
    #1;
    send(1'b1, ADDR_H_INCR, 8'h10, a0);
    send(1'b1, ADDR_M, 8'h00, a0);
    send(1'b1, ADDR_L, 8'h40, a0);
    send(1'b1, DATA0, 8'h5A, a0);
    send(1'b1, ADDR_H_INCR, 8'h10, a0);
    send(1'b1, ADDR_M, 8'h00, a0);
    send(1'b1, ADDR_L, 8'h40, a0);
    send(1'b0, DATA0, 8'h00, a0);
    wait_rsp(a0, lat);
    check_eq("loop_data0", 32'(rsp_rddata), 32'h5A);
    @(posedge clk);
    #1;
    send(1'b0, ADDR_L, 8'h00, a0);
    wait_rsp(a0, lat);
    check_eq("loop_addr_l", 32'(rsp_rddata), 32'h41);

    // Randomized traffic with random idle gaps
    @(posedge clk);
    #1;
    for (int n = 0; n < 120; n++) begin
      send(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), a0);
      repeat ($urandom_range(0, 14)) @(posedge clk);
      #1;
    end
    repeat (2 * P) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
